// File: rtl/bp_mem_cmd_mux_if.sv
// Downstream memory port of bp_mem_cmd_mux: one command out, in-order responses back.
interface bp_mem_cmd_mux_if #(
  parameter int msg_width_p = 128
);
  logic [msg_width_p-1:0] mem_cmd_o;
  logic                   mem_cmd_v_o;
  logic                   mem_cmd_ready_i;
  logic [msg_width_p-1:0] mem_resp_i;
  logic                   mem_resp_v_i;
  logic                   mem_resp_yumi_o;

  modport master (
    output mem_cmd_o,
    output mem_cmd_v_o,
    input  mem_cmd_ready_i,
    input  mem_resp_i,
    input  mem_resp_v_i,
    output mem_resp_yumi_o
  );

  modport slave (
    input  mem_cmd_o,
    input  mem_cmd_v_o,
    output mem_cmd_ready_i,
    output mem_resp_i,
    output mem_resp_v_i,
    input  mem_resp_yumi_o
  );
endinterface

// File: rtl/bp_mem_cmd_mux.sv
// N-channel memory command concentrator: per-channel FIFOs, RR arbiter, in-order resp routing.
// Optional perf counters enabled with `define BP_MEM_CMD_MUX_PERF_EN.
module bp_mem_cmd_mux #(
  parameter int num_channels_p = 2,
  parameter int msg_width_p    = 128,
  parameter int in_els_p       = 2,
  parameter int outstanding_p  = 4,
  localparam int lg_ch_lp  = (num_channels_p > 1) ? $clog2(num_channels_p) : 1,
  localparam int lg_els_lp = $clog2(in_els_p),
  localparam int els_w_lp  = $clog2(in_els_p+1),
  localparam int lg_out_lp = (outstanding_p > 1) ? $clog2(outstanding_p) : 1,
  localparam int cnt_w_lp  = $clog2(outstanding_p+1)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_channels_p*msg_width_p-1:0] cmd_i,
  input  logic [num_channels_p-1:0]          cmd_v_i,
  output logic [num_channels_p-1:0]          cmd_ready_o,
  bp_mem_cmd_mux_if.master                   mem,
  output logic [msg_width_p-1:0]             resp_o,
  output logic [num_channels_p-1:0]          resp_v_o,
  input  logic [num_channels_p-1:0]          resp_yumi_i,
  output logic [cnt_w_lp-1:0]                outstanding_o,
  output logic                               orphan_resp_o
`ifdef BP_MEM_CMD_MUX_PERF_EN
  ,
  output logic [31:0]                        perf_stall_cycles_o,
  output logic [31:0]                        perf_credit_stall_o
`endif
);

  logic [msg_width_p-1:0]    head [num_channels_p];
  logic [num_channels_p-1:0] enq, deq, nonempty;

  for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
    logic [msg_width_p-1:0] mem_q [in_els_p];
    logic [lg_els_lp-1:0]   wr_q, rd_q;
    logic [els_w_lp-1:0]    cnt_q;

    assign cmd_ready_o[c] = (cnt_q != els_w_lp'(in_els_p));
    assign enq[c]         = cmd_v_i[c] & cmd_ready_o[c];
    assign nonempty[c]    = (cnt_q != '0);
    assign head[c]        = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (enq[c])
          wr_q <= (wr_q == lg_els_lp'(in_els_p-1)) ? '0 : wr_q + 1'b1;
        if (deq[c])
          rd_q <= (rd_q == lg_els_lp'(in_els_p-1)) ? '0 : rd_q + 1'b1;
        if (enq[c] != deq[c])
          cnt_q <= enq[c] ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
    end

    // Payload storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
      if (enq[c])
        mem_q[wr_q] <= cmd_i[c*msg_width_p +: msg_width_p];
    end
  end

  logic [lg_ch_lp-1:0] rr_q, grant, idx;
  logic                any_nonempty, credit_ok, issue;

  // Scan downward so the channel closest to the pointer wins.
  always_comb begin
    grant        = '0;
    idx          = '0;
    any_nonempty = 1'b0;
    for (int i = num_channels_p-1; i >= 0; i--) begin
      idx = lg_ch_lp'((int'(rr_q) + i) % num_channels_p);
      if (nonempty[idx]) begin
        grant        = idx;
        any_nonempty = 1'b1;
      end
    end
  end

  assign credit_ok       = (outstanding_o != cnt_w_lp'(outstanding_p));
  assign mem.mem_cmd_v_o = any_nonempty & credit_ok;
  assign mem.mem_cmd_o   = head[grant];
  assign issue           = mem.mem_cmd_v_o & mem.mem_cmd_ready_i;
  assign deq = {num_channels_p{issue}} & (num_channels_p'(1) << grant);

  logic [lg_ch_lp-1:0]  trk_q [outstanding_p];
  logic [lg_out_lp-1:0] trk_wr_q, trk_rd_q;
  logic [lg_ch_lp-1:0]  h;
  logic [cnt_w_lp-1:0]  cnt_q;
  logic                 trk_empty, pop, orphan, orphan_q;

  assign trk_empty = (cnt_q == '0);
  assign h         = trk_q[trk_rd_q];
  assign resp_o    = mem.mem_resp_i;
  assign resp_v_o  = (mem.mem_resp_v_i & !trk_empty)
                   ? (num_channels_p'(1) << h) : '0;
  assign pop       = |(resp_v_o & resp_yumi_i);
  assign orphan    = mem.mem_resp_v_i & trk_empty;
  assign mem.mem_resp_yumi_o = pop | orphan;
  assign outstanding_o = cnt_q;
  assign orphan_resp_o = orphan_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q     <= '0;
      trk_wr_q <= '0;
      trk_rd_q <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      if (issue) begin
        rr_q <= (grant == lg_ch_lp'(num_channels_p-1)) ? '0 : grant + 1'b1;
        trk_wr_q <= (trk_wr_q == lg_out_lp'(outstanding_p-1))
                  ? '0 : trk_wr_q + 1'b1;
      end
      if (pop)
        trk_rd_q <= (trk_rd_q == lg_out_lp'(outstanding_p-1))
                  ? '0 : trk_rd_q + 1'b1;
      if (issue & !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (pop & !issue)
        cnt_q <= cnt_q - 1'b1;
      if (orphan)
        orphan_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue)
      trk_q[trk_wr_q] <= grant;
  end

`ifdef BP_MEM_CMD_MUX_PERF_EN
  logic [31:0] stall_q, credit_q;

  assign perf_stall_cycles_o = stall_q;
  assign perf_credit_stall_o = credit_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_q  <= '0;
      credit_q <= '0;
    end else begin
      if (mem.mem_cmd_v_o & !mem.mem_cmd_ready_i & (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (any_nonempty & !credit_ok & (credit_q != '1))
        credit_q <= credit_q + 1'b1;
    end
  end
`endif

endmodule
